// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC share arbiter: the in-flight tag,
// the requester count and the angle/counter widths.
package cordic_arb_pkg;
  localparam int NUM_REQ   = 2;
  localparam int ANG_WIDTH = 7;
  localparam int CNT_WIDTH = 16;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;
endpackage

// File: rtl/cordic_tag_pipe.sv
// LATENCY-deep tag shift register that runs alongside the engine's own
// register stages, so the exiting tag lines up with the engine result.
module cordic_tag_pipe
  import cordic_arb_pkg::*;
#(
  parameter int LATENCY = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out,
  output logic       any_v
);
  tag_t [LATENCY-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = '0;
    if (!clr) begin
      pipe_d[0] = tag_t'(tag_in);
      for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_v = any_v | pipe_q[i].v;
  end

  assign tag_out = pipe_q[LATENCY-1];
endmodule

// File: rtl/cordic_share_arbiter.sv
// Round-robin share of one pipelined CORDIC engine between two gradient
// requesters. Define CORDIC_ARB_PERF_EN to build the per-requester grant counters.
module cordic_share_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 11,
  parameter int DATA_WIDTH_OUT = 22,
  parameter int LATENCY        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_WIDTH_IN-1:0]  req_x0,
  input  logic [DATA_WIDTH_IN-1:0]  req_y0,
  input  logic [DATA_WIDTH_IN-1:0]  req_x1,
  input  logic [DATA_WIDTH_IN-1:0]  req_y1,
  output logic [DATA_WIDTH_IN-1:0]  eng_x,
  output logic [DATA_WIDTH_IN-1:0]  eng_y,
  input  logic [DATA_WIDTH_OUT-1:0] eng_mag,
  input  logic [ANG_WIDTH-1:0]      eng_ang,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [DATA_WIDTH_OUT-1:0] res_mag,
  output logic [ANG_WIDTH-1:0]      res_ang,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      grant_cnt0,
  output logic [CNT_WIDTH-1:0]      grant_cnt1
);
  logic                      rr_q, rr_d;
  logic                      accept, grant_id;
  tag_t                      issue_q, issue_d;
  tag_t                      tag_exit;
  logic                      tag_any_v;
  logic [DATA_WIDTH_IN-1:0]  eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic [NUM_REQ-1:0]        res_valid_q, res_valid_d;
  logic [DATA_WIDTH_OUT-1:0] res_mag_q, res_mag_d;
  logic [ANG_WIDTH-1:0]      res_ang_q, res_ang_d;

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    accept    = rst_n & en & ~clr & (|req_valid);
    grant_id  = (req_valid == 2'b11) ? rr_q : req_valid[1];
    req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    rr_d      = accept ? ~grant_id : rr_q;
    issue_d   = '{v: accept, id: grant_id};
    eng_x_d   = eng_x_q;
    eng_y_d   = eng_y_q;
    if (accept) begin
      eng_x_d = grant_id ? req_x1 : req_x0;
      eng_y_d = grant_id ? req_y1 : req_y0;
    end
  end

  cordic_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .tag_in  (issue_q),
    .tag_out (tag_exit),
    .any_v   (tag_any_v)
  );

  // A result coinciding with clr is dropped; data registers only move on a valid tag.
  always_comb begin
    res_valid_d = '0;
    res_mag_d   = res_mag_q;
    res_ang_d   = res_ang_q;
    if (!clr && tag_exit.v) begin
      res_valid_d = tag_exit.id ? 2'b10 : 2'b01;
      res_mag_d   = eng_mag;
      res_ang_d   = eng_ang;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      issue_q     <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      res_valid_q <= '0;
      res_mag_q   <= '0;
      res_ang_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      issue_q     <= issue_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      res_valid_q <= res_valid_d;
      res_mag_q   <= res_mag_d;
      res_ang_q   <= res_ang_d;
    end
  end

`ifdef CORDIC_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + CNT_WIDTH'(req_ready[0]);
    cnt1_d = cnt1_q + CNT_WIDTH'(req_ready[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
  assign res_valid = res_valid_q;
  assign res_mag   = res_mag_q;
  assign res_ang   = res_ang_q;
  assign busy      = issue_q.v | tag_any_v | (|res_valid_q);
endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed bench for cordic_share_arbiter with a behavioural LATENCY-stage
// magnitude/angle engine model feeding eng_mag/eng_ang.
module tb_cordic_share_arbiter;
  localparam int DW_IN = 11, DW_OUT = 22, LAT = 7;
`ifdef CORDIC_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0, clr = 1'b0, en = 1'b1;
  logic [1:0]        req_valid = '0, req_ready, res_valid;
  logic [DW_IN-1:0]  req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic [DW_IN-1:0]  eng_x, eng_y;
  logic [DW_OUT-1:0] eng_mag, res_mag;
  logic [6:0]        eng_ang, res_ang;
  logic              busy;
  logic [15:0]       grant_cnt0, grant_cnt1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  cordic_share_arbiter #(.DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .eng_x(eng_x), .eng_y(eng_y), .eng_mag(eng_mag), .eng_ang(eng_ang),
    .res_valid(res_valid), .res_mag(res_mag), .res_ang(res_ang), .busy(busy),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Engine model: LAT register stages from eng_x/eng_y to eng_mag/eng_ang.
  int mag_pipe [LAT];
  int ang_pipe [LAT];

  function automatic int f_mag(input logic signed [DW_IN-1:0] x, input logic signed [DW_IN-1:0] y);
    real xr, yr;
    xr = $itor(x);
    yr = $itor(y);
    return $rtoi($sqrt(xr * xr + yr * yr) + 0.5);
  endfunction

  function automatic int f_ang(input logic signed [DW_IN-1:0] x, input logic signed [DW_IN-1:0] y);
    real a;
    a = $atan2($itor(y), $itor(x)) * 180.0 / 3.14159265358979;
    if (a < 0.0) a = -a;
    return $rtoi(a + 0.5) & 127;
  endfunction

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      mag_pipe[i] <= mag_pipe[i-1];
      ang_pipe[i] <= ang_pipe[i-1];
    end
    mag_pipe[0] <= f_mag(eng_x, eng_y);
    ang_pipe[0] <= f_ang(eng_x, eng_y);
  end

  assign eng_mag = DW_OUT'(mag_pipe[LAT-1]);
  assign eng_ang = 7'(ang_pipe[LAT-1]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; clr = 1'b0; en = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    tick(); tick();
    checks++;
    if ({eng_x, eng_y, res_valid, res_mag, res_ang, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs eng_x=%0d eng_y=%0d res_valid=%b res_mag=%0d res_ang=%0d busy=%b exp=all0",
                         eng_x, eng_y, res_valid, res_mag, res_ang, busy);
    end
    checks++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d,%0d exp=0,0", grant_cnt0, grant_cnt1);
    end
    req_valid = '0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int early = 0;
    do_reset();
    req_x0 = 11'd3; req_y0 = 11'd4; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (eng_x !== 11'd3 || eng_y !== 11'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL single_issue got x=%0d y=%0d busy=%b exp x=3 y=4 busy=1", eng_x, eng_y, busy);
    end
    for (int k = 1; k < LAT + 1; k++) begin
      tick();
      if (res_valid !== 2'b00) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL single_early got=%0d early pulses exp=0", early); end
    tick();
    checks++;
    if (res_valid !== 2'b01 || res_mag < 4 || res_mag > 6 || res_ang < 52 || res_ang > 54) begin
      errors++; $display("FAIL single_result got v=%b mag=%0d ang=%0d exp v=01 mag=5 ang=53", res_valid, res_mag, res_ang);
    end
    tick();
    checks++;
    if (res_valid !== 2'b00 || busy !== 1'b0 || res_mag < 4 || res_mag > 6) begin
      errors++; $display("FAIL single_after got v=%b busy=%b mag=%0d exp v=00 busy=0 mag=5", res_valid, busy, res_mag);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] got_v [4];
    int got_m [4], got_a [4];
    int n = 0;
    do_reset();
    req_x0 = 11'd100; req_y0 = 11'd0; req_x1 = 11'd0; req_y1 = 11'd100;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (res_valid !== 2'b00) begin
        if (n < 4) begin got_v[n] = res_valid; got_m[n] = int'(res_mag); got_a[n] = int'(res_ang); end
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (got_v[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || got_m[i] < 99 || got_m[i] > 101 ||
          ((i % 2 == 0) ? (got_a[i] > 1) : (got_a[i] < 89 || got_a[i] > 91))) begin
        errors++; $display("FAIL rr_result%0d got v=%b mag=%0d ang=%0d exp v=%b mag=100 ang=%0d",
                           i, got_v[i], got_m[i], got_a[i], (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 0 : 90);
      end
    end
    checks++;
    if (grant_cnt0 !== (PERF ? 16'd2 : 16'd0) || grant_cnt1 !== (PERF ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL rr_counters got=%0d,%0d exp=%0d,%0d", grant_cnt0, grant_cnt1, PERF ? 2 : 0, PERF ? 2 : 0);
    end
  endtask

  task automatic test_clr();
    int pulses = 0;
    do_reset();
    req_x0 = 11'd3; req_y0 = 11'd4; req_valid = 2'b01;
    tick(); tick(); tick();
    req_valid = '0;
    tick();
    clr = 1'b1; req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL clr_ready got=%b exp=00", req_ready); end
    tick();
    clr = 1'b0; req_valid = '0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 2'b00) begin
      errors++; $display("FAIL clr_busy got busy=%b v=%b exp busy=0 v=00", busy, res_valid);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (res_valid !== 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL clr_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_reset();
    req_x0 = 11'd3; req_y0 = 11'd4; req_valid = 2'b01;
    for (int k = 0; k < 10; k++) tick();
    req_valid = '0;
    checks++;
    if (res_mag < 4 || res_mag > 6 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got mag=%0d busy=%b exp mag=5 busy=1", res_mag, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, eng_x, eng_y, res_valid, res_mag, res_ang, busy} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs ready=%b eng_x=%0d res_valid=%b res_mag=%0d res_ang=%0d busy=%b exp=all0",
                         req_ready, eng_x, res_valid, res_mag, res_ang, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (res_valid !== 2'b00 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mid_after_release got=%0d active cycles exp=0", pulses); end
  endtask

  task automatic test_enable();
    int bad = 0;
    do_reset();
    en = 1'b0; req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req_ready !== 2'b00 || res_valid !== 2'b00 || busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_low got=%0d active cycles exp=0", bad); end
    req_valid = '0; en = 1'b1;
  endtask

  task automatic test_counters();
    do_reset();
    req_x1 = 11'd5; req_y1 = 11'd0; req_valid = 2'b10;
    for (int k = 0; k < 65537; k++) tick();
    req_valid = '0;
    checks++;
    if (grant_cnt1 !== (PERF ? 16'd1 : 16'd0) || grant_cnt0 !== 16'd0) begin
      errors++; $display("FAIL cnt_wrap got cnt0=%0d cnt1=%0d exp cnt0=0 cnt1=%0d", grant_cnt0, grant_cnt1, PERF ? 1 : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin mag_pipe[i] = 0; ang_pipe[i] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_clr();
    test_reset_mid();
    test_enable();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
